// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   fetch_state_e    : fetch FSM states
//   RESET_PC_DEFAULT : default PC loaded on reset
//   NOP_INSTR        : instruction word used for IF/ID bubbles
package mips_pkg;

    typedef enum logic [1:0] {
        StIssue = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset    : clock, asynchronous active-high reset
//   stall_i       : hold current contents
//   flush_i       : force a bubble (when not stalled)
//   we_i          : a real instruction is offered this cycle
//   instr_i       : offered instruction word
//   pc_plus4_i    : PC+4 of the offered instruction
//   instr_o       : registered instruction (InstrD)
//   pc_plus4_o    : registered PC+4 (PCPlus4D)
//   valid_o       : registered instruction is real (ValidD)
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        we_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic        valid_d, valid_q;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (!stall_i) begin
            // Whenever the register is free to move, anything other than a
            // clean write leaves a bubble behind.
            if (we_i && !flush_i) begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end else begin
                instr_d    = NOP_INSTR;
                pc_plus4_d = 32'h0000_0000;
                valid_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM (issue / wait / hold) and
// the IF/ID register.
//   clk, reset             : clock, asynchronous active-high reset
//   PCSrcD, PCBranchD      : taken branch and its target from decode
//   JumpD, PCJumpD         : jump and its target from decode
//   StallD, FlushD         : hazard-unit controls for IF/ID
//   imem_req, imem_addr    : fetch request pulse and address (= PCF)
//   imem_rdata, imem_valid : instruction memory response
//   InstrD, PCPlus4D       : IF/ID contents
//   ValidD                 : IF/ID holds a real instruction
//   FetchBusyF             : a request is outstanding
module fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    import mips_pkg::*;

    fetch_state_e state_d, state_q;
    logic [31:0]  pcf_d, pcf_q;
    logic [31:0]  buf_d, buf_q;
    logic         discard_d, discard_q;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         ifid_we;
    logic [31:0]  ifid_instr;

    // A stalled decode stage cannot have resolved its branch yet.
    assign redirect = (PCSrcD | JumpD) & ~StallD;
    assign target   = PCSrcD ? PCBranchD : PCJumpD;
    assign pc_plus4 = pcf_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        buf_d      = buf_q;
        discard_d  = discard_q;
        imem_req   = 1'b0;
        ifid_we    = 1'b0;
        ifid_instr = buf_q;
        unique case (state_q)
            StIssue: begin
                imem_req = 1'b1;
                state_d  = StWait;
                if (redirect) begin
                    // The request just issued is wrong-path; drop its response.
                    pcf_d     = target;
                    discard_d = 1'b1;
                end
            end
            StWait: begin
                if (imem_valid) begin
                    state_d = StIssue;
                    if (redirect) begin
                        pcf_d     = target;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (!StallD) begin
                        ifid_we    = 1'b1;
                        ifid_instr = imem_rdata;
                        pcf_d      = pc_plus4;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = StHold;
                    end
                end else if (redirect) begin
                    pcf_d     = target;
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = StIssue;
                end else if (!StallD) begin
                    ifid_we    = 1'b1;
                    ifid_instr = buf_q;
                    pcf_d      = pc_plus4;
                    state_d    = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIssue;
            pcf_q     <= RESET_PC;
            buf_q     <= 32'h0000_0000;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            buf_q     <= buf_d;
            discard_q <= discard_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (StallD),
        .flush_i    (FlushD),
        .we_i       (ifid_we),
        .instr_i    (ifid_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (InstrD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

    assign imem_addr  = pcf_q;
    assign FetchBusyF = (state_q == StWait);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        StallD;
    logic        FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchBusyF;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned lat;
    int unsigned cnt;
    logic [31:0] paddr;

    fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusyF (FetchBusyF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at address a is 32'h2108_0000 + a/4 + 1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2108_0000 + (a >> 2) + 32'd1;
    endfunction

    // Instruction memory model with lat-cycle response latency (lat >= 1).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_valid <= 1'b0;
            imem_rdata <= 32'h0;
            cnt        <= 0;
        end else begin
            imem_valid <= 1'b0;
            if (imem_req) begin
                if (lat == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(imem_addr);
                end else begin
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(paddr);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        lat       = 1;
        reset     = 1'b1;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        JumpD     = 1'b0;
        PCJumpD   = 32'h0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        tick();
        tick();
        check("rst_instr", InstrD, 32'h0);
        check("rst_pcp4", PCPlus4D, 32'h0);
        check("rst_valid", ValidD, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_busy", FetchBusyF, 1'b0);

        // First request right after reset release; stall 3 cycles across the response.
        reset = 1'b0;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("wait_busy", FetchBusyF, 1'b1);
        check("wait_req", imem_req, 1'b0);
        StallD = 1'b1;
        tick();
        check("hold_busy", FetchBusyF, 1'b0);
        check("hold_req", imem_req, 1'b0);
        check("hold_frozen_v", ValidD, 1'b0);
        tick();
        check("hold2_frozen_v", ValidD, 1'b0);
        check("hold2_addr", imem_addr, 32'h0);
        tick();
        StallD = 1'b0;
        check("hold3_req", imem_req, 1'b0);
        tick();
        check("rel_instr", InstrD, 32'h2108_0001);
        check("rel_pcp4", PCPlus4D, 32'h4);
        check("rel_valid", ValidD, 1'b1);
        check("rel_addr", imem_addr, 32'h4);
        check("rel_req", imem_req, 1'b1);
        tick();
        check("nodup_valid", ValidD, 1'b0);
        tick();
        check("f4_instr", InstrD, 32'h2108_0002);
        check("f4_pcp4", PCPlus4D, 32'h8);
        check("f8_addr", imem_addr, 32'h8);

        // Branch during WAIT at PCF=8, response arrives the same cycle.
        tick();
        check("br_busy", FetchBusyF, 1'b1);
        PCSrcD    = 1'b1;
        PCBranchD = 32'h0000_0040;
        tick();
        PCSrcD = 1'b0;
        check("br_addr", imem_addr, 32'h40);
        check("br_req", imem_req, 1'b1);
        check("br_bubble_v", ValidD, 1'b0);
        check("br_bubble_i", InstrD, 32'h0);
        tick();
        tick();
        check("br_instr", InstrD, 32'h2108_0011);
        check("br_pcp4", PCPlus4D, 32'h44);

        // Branch and jump together in ISSUE: branch wins, in-flight response dropped.
        PCSrcD    = 1'b1;
        PCBranchD = 32'h80;
        JumpD     = 1'b1;
        PCJumpD   = 32'h100;
        tick();
        PCSrcD = 1'b0;
        JumpD  = 1'b0;
        check("prio_addr", imem_addr, 32'h80);
        check("prio_busy", FetchBusyF, 1'b1);
        tick();
        check("prio_drop_v", ValidD, 1'b0);
        check("prio_req", imem_req, 1'b1);
        check("prio_addr2", imem_addr, 32'h80);
        tick();
        tick();
        check("prio_instr", InstrD, 32'h2108_0021);
        check("prio_pcp4", PCPlus4D, 32'h84);

        // Flush while the response is valid: bubble, PC still advances.
        tick();
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        check("flush_valid", ValidD, 1'b0);
        check("flush_instr", InstrD, 32'h0);
        check("flush_addr", imem_addr, 32'h88);
        tick();
        tick();
        check("post_flush_instr", InstrD, 32'h2108_0023);
        check("post_flush_pcp4", PCPlus4D, 32'h8C);

        // Jump in WAIT before the response (2-cycle memory): late response dropped.
        lat = 2;
        tick();
        check("slow_wait_v", imem_valid, 1'b0);
        JumpD   = 1'b1;
        PCJumpD = 32'h20;
        tick();
        JumpD = 1'b0;
        check("jw_busy", FetchBusyF, 1'b1);
        check("jw_addr", imem_addr, 32'h20);
        check("jw_req", imem_req, 1'b0);
        check("jw_valid", ValidD, 1'b0);
        tick();
        check("jw_drop_req", imem_req, 1'b1);
        check("jw_drop_v", ValidD, 1'b0);
        tick();
        check("jw_wait", FetchBusyF, 1'b1);

        // Reset in WAIT at PCF=0x20.
        reset = 1'b1;
        #1;
        check("mrst_busy", FetchBusyF, 1'b0);
        check("mrst_addr", imem_addr, 32'h0);
        check("mrst_instr", InstrD, 32'h0);
        check("mrst_pcp4", PCPlus4D, 32'h0);
        lat = 1;
        tick();
        reset = 1'b0;
        check("mrst_req", imem_req, 1'b1);
        check("mrst_addr2", imem_addr, 32'h0);
        tick();
        tick();
        check("mrst_instr2", InstrD, 32'h2108_0001);
        check("mrst_addr4", imem_addr, 32'h4);

        // PC wrap: jump to 0xFFFF_FFFC, PC+4 wraps to 0.
        JumpD   = 1'b1;
        PCJumpD = 32'hFFFF_FFFC;
        tick();
        JumpD = 1'b0;
        tick();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_instr", InstrD, 32'h6108_0000);
        check("wrap_pcp4", PCPlus4D, 32'h0);
        check("wrap_valid", ValidD, 1'b1);
        check("wrap_next", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
